// File: rtl/tdc_link_pkg.sv
// Shared definitions for the TDC measurement link.
// The control FSM (writer) and the FIFO reader both import this package so they
// agree on the packet header and on where each field sits in the 32-bit FIFO word.
//   - rd_state_e     : reader FSM state encoding (3 bits)
//   - TDC_PKT_HEADER : first byte of every serial packet
//   - CALIB_DIFF_MSB / TIME1_MSB : MSB positions of the two 16-bit payload fields
package tdc_link_pkg;

    typedef enum logic [2:0] {
        StIdle     = 3'd0,
        StPop      = 3'd1,
        StWaitData = 3'd2,
        StSend     = 3'd3,
        StGuard    = 3'd4,
        StWaitTx   = 3'd5
    } rd_state_e;

    localparam logic [7:0] TDC_PKT_HEADER = 8'hAA;

    // FIFO word layout: {calib_diff[15:0], time1[15:0]}
    localparam int unsigned CALIB_DIFF_MSB = 31;
    localparam int unsigned TIME1_MSB      = 15;

endpackage

// File: rtl/tdc_fifo_reader.sv
// Drain side of the TDC measurement FIFO.
// Pops one 32-bit word, frames it as {header, 4 payload bytes, XOR checksum}
// and hands the bytes one at a time to the byte-wide serial transmitter.
// Ports:
//   clk, rst     : system clock, asynchronous active-high reset
//   enable       : 0 blocks new pops; a packet in progress still completes
//   fifo_empty   : FIFO empty flag (sampled only while idle)
//   fifo_dout    : FIFO read data, valid FIFO_RD_LATENCY cycles after fifo_rd_en
//   fifo_rd_en   : one-cycle pop strobe
//   tx_busy      : TX busy; rises the cycle after tx_new_data
//   tx_data      : byte to transmit, valid with tx_new_data
//   tx_new_data  : one-cycle byte strobe
//   pkt_count    : packets fully sent (wraps)
//   busy         : high whenever the FSM is not idle
// All outputs come straight from flops.
module tdc_fifo_reader
    import tdc_link_pkg::*;
#(
    parameter logic [7:0]  HEADER_BYTE     = TDC_PKT_HEADER,
    parameter int unsigned FIFO_RD_LATENCY = 1,
    parameter bit          CHECKSUM_EN     = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    input  logic        fifo_empty,
    input  logic [31:0] fifo_dout,
    output logic        fifo_rd_en,
    input  logic        tx_busy,
    output logic [7:0]  tx_data,
    output logic        tx_new_data,
    output logic [15:0] pkt_count,
    output logic        busy
);

    localparam logic [2:0] LAST_IDX = CHECKSUM_EN ? 3'd5 : 3'd4;
    localparam logic [1:0] RD_LAT   = 2'(FIFO_RD_LATENCY);

    rd_state_e   state_q, state_d;
    logic [1:0]  wait_cnt_q, wait_cnt_d;
    logic [31:0] word_q, word_d;
    logic [7:0]  chk_q, chk_d;
    logic [2:0]  byte_idx_q, byte_idx_d;
    logic [15:0] pkt_count_q, pkt_count_d;
    logic        fifo_rd_en_q, fifo_rd_en_d;
    logic        tx_new_data_q, tx_new_data_d;
    logic [7:0]  tx_data_q, tx_data_d;
    logic        busy_q;
    logic [7:0]  next_byte;

    // Byte order on the wire: header, calib_diff MSB/LSB, time1 MSB/LSB, checksum.
    function automatic logic [7:0] pkt_byte(input logic [2:0]  idx,
                                            input logic [31:0] word,
                                            input logic [7:0]  chk);
        logic [7:0] b;
        case (idx)
            3'd0:    b = HEADER_BYTE;
            3'd1:    b = word[CALIB_DIFF_MSB -: 8];
            3'd2:    b = word[CALIB_DIFF_MSB - 8 -: 8];
            3'd3:    b = word[TIME1_MSB -: 8];
            3'd4:    b = word[TIME1_MSB - 8 -: 8];
            default: b = chk;
        endcase
        return b;
    endfunction

    // Outputs are computed for the state being entered and registered, so the
    // strobes line up exactly with the POP and SEND states.
    always_comb begin
        state_d       = state_q;
        wait_cnt_d    = wait_cnt_q;
        word_d        = word_q;
        chk_d         = chk_q;
        byte_idx_d    = byte_idx_q;
        pkt_count_d   = pkt_count_q;
        fifo_rd_en_d  = 1'b0;
        tx_new_data_d = 1'b0;
        tx_data_d     = tx_data_q;
        next_byte     = pkt_byte(byte_idx_q + 3'd1, word_q, chk_q);

        unique case (state_q)
            StIdle: begin
                if (enable && !fifo_empty) begin
                    state_d      = StPop;
                    fifo_rd_en_d = 1'b1;
                end
            end
            StPop: begin
                wait_cnt_d = RD_LAT;
                state_d    = StWaitData;
            end
            StWaitData: begin
                wait_cnt_d = wait_cnt_q - 2'd1;
                // Counter about to hit zero: read data is valid this cycle.
                if (wait_cnt_q == 2'd1) begin
                    word_d        = fifo_dout;
                    chk_d         = '0;
                    byte_idx_d    = '0;
                    tx_data_d     = HEADER_BYTE;
                    tx_new_data_d = 1'b1;
                    state_d       = StSend;
                end
            end
            StSend: begin
                state_d = StGuard;
            end
            StGuard: begin
                // tx_busy lags the strobe by a cycle, so it is not trusted here.
                state_d = StWaitTx;
            end
            StWaitTx: begin
                if (!tx_busy) begin
                    if (byte_idx_q == LAST_IDX) begin
                        pkt_count_d = pkt_count_q + 16'd1;
                        state_d     = StIdle;
                    end else begin
                        byte_idx_d    = byte_idx_q + 3'd1;
                        tx_data_d     = next_byte;
                        tx_new_data_d = 1'b1;
                        // Only payload bytes (indices 1..4) feed the checksum.
                        if (byte_idx_q < 3'd4) begin
                            chk_d = chk_q ^ next_byte;
                        end
                        state_d = StSend;
                    end
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= StIdle;
            wait_cnt_q    <= '0;
            word_q        <= '0;
            chk_q         <= '0;
            byte_idx_q    <= '0;
            pkt_count_q   <= '0;
            fifo_rd_en_q  <= 1'b0;
            tx_new_data_q <= 1'b0;
            tx_data_q     <= '0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            wait_cnt_q    <= wait_cnt_d;
            word_q        <= word_d;
            chk_q         <= chk_d;
            byte_idx_q    <= byte_idx_d;
            pkt_count_q   <= pkt_count_d;
            fifo_rd_en_q  <= fifo_rd_en_d;
            tx_new_data_q <= tx_new_data_d;
            tx_data_q     <= tx_data_d;
            busy_q        <= (state_d != StIdle);
        end
    end

    assign fifo_rd_en  = fifo_rd_en_q;
    assign tx_new_data = tx_new_data_q;
    assign tx_data     = tx_data_q;
    assign pkt_count   = pkt_count_q;
    assign busy        = busy_q;

endmodule

// File: doc/tdc_fifo_reader.md
Name: tdc_fifo_reader

Overview:
Drain side of the TDC measurement FIFO. It pops one 32-bit word {calib_diff[15:0], time1[15:0]}, frames it as a 6-byte packet (header, 4 payload bytes, XOR checksum) and hands the bytes one at a time to the byte-wide serial transmitter. It sits between the FIFO read port and the serial TX block, on the same clock as the TDC control FSM.

Parameters:
HEADER_BYTE, 8'hAA, first byte of every packet.
FIFO_RD_LATENCY, 1, cycles from fifo_rd_en to valid fifo_dout; legal values 1 or 2.
CHECKSUM_EN, 1, 1 appends the XOR checksum byte; 0 gives 5-byte packets.

Ports:
clk  in  1  system clock
rst  in  1  reset, asynchronous, active-high
enable  in  1  0 blocks new FIFO pops; a packet already in progress still completes
fifo_empty  in  1  FIFO empty flag
fifo_dout  in  32  FIFO read data, {calib_diff, time1}
fifo_rd_en  out  1  one-cycle pop strobe
tx_busy  in  1  serial TX busy; asserts the cycle after tx_new_data
tx_data  out  8  byte to transmit
tx_new_data  out  1  one-cycle strobe; tx_data is valid in the same cycle
pkt_count  out  16  packets fully sent, wraps at 16'hFFFF -> 0
busy  out  1  high in every state except IDLE

Behaviour:
- Reset (asynchronous assert) forces: state=IDLE, fifo_rd_en=0, tx_new_data=0, tx_data=0, pkt_count=0, busy=0, internal word and checksum registers=0. All outputs are registered.
- IDLE: if enable && !fifo_empty, go to POP; otherwise stay.
- POP: fifo_rd_en=1 for exactly one cycle, load wait counter = FIFO_RD_LATENCY, go to WAIT_DATA.
- WAIT_DATA: decrement the counter. When it reaches 0, latch fifo_dout into word_q, clear chk_q, set byte_idx=0, go to SEND.
- SEND: drive tx_data = byte(byte_idx) and pulse tx_new_data for one cycle.
  - Byte order: 0 = HEADER_BYTE; 1 = word_q[31:24]; 2 = word_q[23:16]; 3 = word_q[15:8]; 4 = word_q[7:0]; 5 = chk_q.
  - chk_q ^= byte for indices 1..4 only. The header is not included; the checksum is the XOR of the 4 payload bytes.
  - Go to GUARD.
- GUARD: one cycle in which tx_busy is ignored, because the TX busy flag lags the strobe by a cycle. Go to WAIT_TX.
- WAIT_TX: stay while tx_busy=1. When tx_busy=0:
  - If byte_idx is the last index (5 with CHECKSUM_EN=1, 4 with CHECKSUM_EN=0): pkt_count += 1, go to IDLE.
  - Otherwise byte_idx += 1, go to SEND.
- Throughput: at most one packet in flight; no pop happens until the previous packet has fully left the TX.
- Minimum packet duration: 3 + FIFO_RD_LATENCY + 3 cycles per byte (SEND, GUARD, WAIT_TX). A full packet is never shorter than 18 + FIFO_RD_LATENCY + 3 cycles; bench timing must use this bound.
- fifo_empty is sampled only in IDLE. fifo_rd_en is never asserted while fifo_empty=1.
- enable deasserted mid-packet: the packet finishes, then the block holds in IDLE.
- tx_busy stuck high: the block waits indefinitely in WAIT_TX. There is no timeout, and this is the specified behaviour.
- Reset asserted mid-packet: immediate return to IDLE. The partial packet is abandoned and the popped word is lost. pkt_count is cleared.
- tx_new_data and fifo_rd_en are never high in the same cycle.

Decomposition:
- Shared package tdc_link_pkg holds:
  - state encoding localparams (IDLE, POP, WAIT_DATA, SEND, GUARD, WAIT_TX; 3 bits);
  - TDC_PKT_HEADER = 8'hAA;
  - payload field positions (CALIB_DIFF_MSB = 31, TIME1_MSB = 15).
- The TDC control FSM imports the same field positions so writer and reader agree.
- No sub-module. The byte mux and XOR are small enough to stay inline.

Test Plan:
1. FIFO holds 32'h2EE0_0190; tx_busy modelled as 10 cycles after each strobe. Required: bytes AA 2E E0 01 90 and checksum 2E^E0^01^90 = 0x5F, one fifo_rd_en pulse, pkt_count = 1, back to IDLE.
2. Three words queued back-to-back. Required: 18 bytes in order, exactly 3 pops, each pop only after the previous packet's final WAIT_TX exit, pkt_count = 3.
3. fifo_empty = 1 with enable = 1 for 100 cycles. Required: no fifo_rd_en, no tx_new_data, busy = 0.
4. Drop enable during byte 2 of a packet. Required: all 6 bytes are sent, then no further pop while 2 more words wait; re-raising enable resumes popping.
5. Assert rst asynchronously during WAIT_TX of byte 3. Required: outputs go to reset values without a clock edge; the next packet after release starts with AA.
6. FIFO_RD_LATENCY = 2, CHECKSUM_EN = 0, word 32'hFFFF_0000. Required: data latched 2 cycles after the pop; 5-byte packet AA FF FF 00 00. Also preload pkt_count near wrap (65535 packets, or force), and check the next packet wraps it to 0.
